erode_3x3: RTL and testbench

Binary 3x3 morphological erosion for the video pipeline, the complement of the dilation stage: together they form opening/closing filters on thresholded video. It includes its own two-line window buffer, column/row position counters and border masking, so it connects directly to a pixel stream (de/hsync/vsync/data) without an external matrix generator. A pixel is foreground when any bit of its 24-bit data is set. Output is 24'hFFFFFF when the full 3x3 neighbourhood is foreground, else 24'h000000.

---
 rtl/erode_3x3.sv | 154 +++++++++++++++
 tb/tb_erode_3x3.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/erode_3x3.sv
// Binary 3x3 erosion on a de/hsync/vsync pixel stream with built-in line buffers and border masking.
// Define ERODE_BORDER_CLEAR_EN to force zero output for any window touching the image border.
module erode_3x3 #(
  parameter int COL = 1024,
  parameter int ROW = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RGB_de,
  input  logic        RGB_hsync,
  input  logic        RGB_vsync,
  input  logic [23:0] RGB_data,
  output logic        erode_de,
  output logic        erode_hsync,
  output logic        erode_vsync,
  output logic [23:0] erode_data
);

  localparam int CW = $clog2(COL);
  localparam int RW = $clog2(ROW);
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          vsync_d;
  logic          vsync_rise;
  logic          cur;

  assign vsync_rise = RGB_vsync & ~vsync_d;
  assign cur        = |RGB_data;

  // A vsync edge wins over the increment, so a coincident beat uses the old position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= RGB_vsync;
      if (vsync_rise) begin
        col <= '0;
        row <= '0;
      end else if (RGB_de) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  logic lb1 [COL];
  logic lb2 [COL];
  logic lb1_rd;
  logic lb2_rd;

  assign lb1_rd = lb1[col];
  assign lb2_rd = lb2[col];

  always_ff @(posedge clk) begin
    if (RGB_de) begin
      lb1[col] <= cur;
      lb2[col] <= lb1[col];
    end
  end

  // Bit 2 of each window row is the newest column (c), bit 0 the oldest (c-2).
  logic [2:0] win_top;
  logic [2:0] win_mid;
  logic [2:0] win_bot;
  logic       mask_top;
  logic       mask_mid;
  logic       mask_c1;
  logic       mask_c2;
  logic       valid1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_top  <= '0;
      win_mid  <= '0;
      win_bot  <= '0;
      mask_top <= 1'b0;
      mask_mid <= 1'b0;
      mask_c1  <= 1'b0;
      mask_c2  <= 1'b0;
      valid1   <= 1'b0;
    end else begin
      valid1 <= RGB_de;
      if (RGB_de) begin
        win_top  <= {lb2_rd, win_top[2:1]};
        win_mid  <= {lb1_rd, win_mid[2:1]};
        win_bot  <= {cur, win_bot[2:1]};
        mask_top <= (row < RW'(2));
        mask_mid <= (row == RW'(0));
        mask_c2  <= (col < CW'(2));
        mask_c1  <= (col == CW'(0));
      end
    end
  end

  logic [2:0] col_mask;
  logic [2:0] top_m;
  logic [2:0] mid_m;
  logic [2:0] bot_m;

  // Out-of-image taps read as foreground so stale buffer contents cannot leak in.
  assign col_mask = {1'b0, mask_c1, mask_c2};
  assign top_m    = win_top | col_mask | {3{mask_top}};
  assign mid_m    = win_mid | col_mask | {3{mask_mid}};
  assign bot_m    = win_bot | col_mask;

  logic [2:0] row_and;
  logic       pass2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_and <= '0;
      pass2   <= 1'b0;
    end else begin
      row_and <= {&top_m, &mid_m, &bot_m};
`ifdef ERODE_BORDER_CLEAR_EN
      pass2   <= valid1 & ~(mask_top | mask_c2);
`else
      pass2   <= valid1;
`endif
    end
  end

  logic [2:0] de_sr;
  logic [2:0] hs_sr;
  logic [2:0] vs_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erode_data <= '0;
      de_sr      <= '0;
      hs_sr      <= '0;
      vs_sr      <= '0;
    end else begin
      erode_data <= (pass2 && (&row_and)) ? 24'hFFFFFF : 24'h000000;
      de_sr      <= {de_sr[1:0], RGB_de};
      hs_sr      <= {hs_sr[1:0], RGB_hsync};
      vs_sr      <= {vs_sr[1:0], RGB_vsync};
    end
  end

  assign erode_de    = de_sr[2];
  assign erode_hsync = hs_sr[2];
  assign erode_vsync = vs_sr[2];

endmodule

// File: tb/tb_erode_3x3.sv
// Self-checking bench for erode_3x3: directed and random frames scored against a neighbourhood model.
module tb_erode_3x3;

   localparam int COL = 8;
   localparam int ROW = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RGB_de = 1'b0;
   logic        RGB_hsync = 1'b0;
   logic        RGB_vsync = 1'b0;
   logic [23:0] RGB_data = '0;
   logic        erode_de;
   logic        erode_hsync;
   logic        erode_vsync;
   logic [23:0] erode_data;

   int checkCount = 0;
   int passCount = 0;
   int mode = 1;
   logic [23:0] pix [ROW][COL];
   logic [23:0] expQ [$];
   logic [2:0]  hist [3];

   erode_3x3 #(.COL(COL), .ROW(ROW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .RGB_de(RGB_de),
      .RGB_hsync(RGB_hsync),
      .RGB_vsync(RGB_vsync),
      .RGB_data(RGB_data),
      .erode_de(erode_de),
      .erode_hsync(erode_hsync),
      .erode_vsync(erode_vsync),
      .erode_data(erode_data)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
   endtask

   // Erosion of the 3x3 neighbourhood ending at (r,c); pixels outside the image count as foreground.
   function automatic logic expectedAt(input int r, input int c);
      logic e;
      e = 1'b1;
`ifdef ERODE_BORDER_CLEAR_EN
      if (r < 2 || c < 2) return 1'b0;
`endif
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            if (r - dr >= 0 && c - dc >= 0 && pix[r - dr][c - dc] == 24'h0) e = 1'b0;
      return e;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      RGB_de = 1'b0;
      RGB_hsync = 1'b0;
      RGB_vsync = 1'b0;
      RGB_data = '0;
      repeat (n) cycle();
   endtask

   task automatic fillFrame(input int kind);
      for (int r = 0; r < ROW; r++)
         for (int c = 0; c < COL; c++)
            case (kind)
               0: pix[r][c] = 24'h000000;
               1: pix[r][c] = 24'hFFFFFF;
               2: pix[r][c] = 24'h000001;
               default: pix[r][c] = ($urandom_range(0, 7) != 0) ? 24'($urandom | 1) : 24'h0;
            endcase
   endtask

   // Drives one frame; gapMode 0 contiguous, 1 de every other clk, 2 random gaps. rstRow >= 0 pulses reset mid-row.
   task automatic applyStimulus(input int gapMode, input int rstRow);
      int gaps;
      RGB_vsync = 1'b1;
      repeat (3) cycle();
      RGB_vsync = 1'b0;
      repeat (2) cycle();
      for (int r = 0; r < ROW; r++) begin
         RGB_hsync = 1'b1;
         repeat (2) cycle();
         RGB_hsync = 1'b0;
         cycle();
         for (int c = 0; c < COL; c++) begin
            if (r == rstRow && c == 3) begin
               RGB_de = 1'b0;
               rst_n = 1'b0;
               #1;
               checkOutput("rst_async", {5'b0, erode_de, erode_hsync, erode_vsync, erode_data}, 32'h0);
               repeat (2) cycle();
               rst_n = 1'b1;
            end
            gaps = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
               RGB_de = 1'b0;
               RGB_data = 24'($urandom);
               cycle();
            end
            RGB_de = 1'b1;
            RGB_data = pix[r][c];
            if (mode == 0) expQ.push_back(expectedAt(r, c) ? 24'hFFFFFF : 24'h000000);
            cycle();
         end
         RGB_de = 1'b0;
         RGB_data = '0;
         repeat (3) cycle();
      end
   endtask

   // Mode 0 scores everything, mode 1 only checks reset behaviour, mode 2 checks sync timing and idle data.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst_hold", {5'b0, erode_de, erode_hsync, erode_vsync, erode_data}, 32'h0);
      end else if (mode != 1) begin
         checkOutput("sync_delay", {29'b0, erode_de, erode_hsync, erode_vsync}, {29'b0, hist[2]});
         if (!erode_de) begin
            checkOutput("idle_data", {8'b0, erode_data}, 32'h0);
         end else if (mode == 0) begin
            checkOutput("beat_queued", {31'b0, expQ.size() > 0}, 32'h1);
            if (expQ.size() > 0) checkOutput("beat_data", {8'b0, erode_data}, {8'b0, expQ.pop_front()});
         end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {RGB_de, RGB_hsync, RGB_vsync};
   end

   initial begin
      hist[0] = '0;
      hist[1] = '0;
      hist[2] = '0;
      #12;
      checkOutput("reset_state", {5'b0, erode_de, erode_hsync, erode_vsync, erode_data}, 32'h0);
      #10;
      rst_n = 1'b1;
      idle(4);
      mode = 0;

      fillFrame(0); applyStimulus(0, -1);
      fillFrame(1); applyStimulus(0, -1);
      fillFrame(1); pix[3][3] = 24'h0; applyStimulus(0, -1);
      fillFrame(2); applyStimulus(0, -1);
      fillFrame(1); applyStimulus(1, -1);
      for (int i = 0; i < 4; i++) begin
         fillFrame(3);
         applyStimulus(2, -1);
      end
      idle(5);

      mode = 2;
      for (int i = 0; i < 200; i++) begin
         RGB_de = 1'($urandom_range(0, 1));
         RGB_hsync = 1'($urandom_range(0, 1));
         RGB_vsync = 1'($urandom_range(0, 1));
         RGB_data = 24'($urandom);
         cycle();
      end
      idle(5);
      mode = 0;

      fillFrame(3); applyStimulus(0, -1);
      idle(5);

      mode = 1;
      fillFrame(1);
      applyStimulus(0, 2);
      idle(5);
      mode = 0;

      fillFrame(1); applyStimulus(0, -1);
      fillFrame(3); applyStimulus(2, -1);
      idle(6);
      checkOutput("leftover", expQ.size(), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
